symm_conv_ctrl: RTL and testbench
=================================

// Module: symm_conv_ctrl
// PURPOSE
//  Sequencer for the symmetric-decorrelation convergence check of the FastICA core.
//  After each W update it enables the 4x4 SYMM_ABS stage for one cycle (Q13, 1.0 = 8192).
//  It then scans that stage's 16 deviation outputs through an external mux and compares
//  each against a tolerance. Reports converged / timeout to the top-level iteration FSM.
// PARAMETERS
//  DW        26   data width of deviation values and tolerance (signed Q13)
//  NELEM     16   number of deviation elements scanned (4x4 matrix)
//  MAX_ITER  200  iteration limit; timeout flagged when reached without convergence
//  ITER_W    8    width of iteration counter (must hold MAX_ITER)
// PORTS
//  clk_cvg   in   1       clock; all state on rising edge
//  rst_cvg   in   1       synchronous, active-high reset
//  start     in   1       request one convergence check (honoured in IDLE only)
//  iter_clr  in   1       clear iteration counter (new run)
//  tol       in   DW      tolerance, non-negative Q13; sampled on accepted start
//  en_abs    out  1       enable to SYMM_ABS; one-cycle pulse
//  abs_sel   out  4       element index to external 16:1 mux (row*4+col)
//  abs_val   in   DW      muxed deviation value selected by abs_sel (same cycle)
//  busy      out  1       high from the cycle after accepted start until done
//  done      out  1       one-cycle pulse; converged/timeout valid from this cycle
//  converged out  1       all NELEM deviations <= tol; held until next accepted start
//  timeout   out  1       not converged and iter_cnt reached MAX_ITER; held like converged
//  iter_cnt  out  ITER_W  completed checks since iter_clr/reset; saturates at MAX_ITER
// BEHAVIOUR
//  Reset: state IDLE; en_abs, abs_sel, busy, done, converged, timeout, iter_cnt all 0.
//  FSM: IDLE -> LATCH -> SCAN -> DECIDE -> IDLE.
//  IDLE: start=1 registers tol, clears converged/timeout, goes to LATCH.
//  LATCH (1 cycle): en_abs=1, busy=1. SYMM_ABS captures on this cycle's ending edge.
//  SCAN (NELEM cycles): abs_sel = 0..NELEM-1, one per cycle, starting at 0 on entry.
//   Each cycle: abs_val > tol_q or abs_val negative (MSB=1) -> set sticky exceed flag.
//   Compare is signed DW-bit, no truncation. Exits after abs_sel = NELEM-1.
//  DECIDE (1 cycle): done=1, busy=0.
//   converged = !exceed. iter_cnt += 1, saturating at MAX_ITER.
//   timeout = !exceed && (incremented iter_cnt == MAX_ITER) is wrong: timeout = exceed &&
//   (incremented iter_cnt == MAX_ITER). Next state IDLE.
//  Latency: start in cycle 0 -> en_abs cycle 1 -> scan cycles 2..17 -> done cycle 18.
//   Next start is accepted in cycle 19 (done and start in same cycle: start ignored).
//  abs_sel holds its last value (NELEM-1) outside SCAN. en_abs is 0 in all other states.
//  start while busy or in DECIDE: ignored, no queueing.
//  iter_clr: clears iter_cnt in any state.
//   Simultaneous with DECIDE increment: clear wins (iter_cnt=0). Does not abort a check.
//  start+iter_clr in same IDLE cycle: both honoured; that check counts as iteration 1.
//  iter_cnt already at MAX_ITER: stays MAX_ITER. timeout re-asserts on each failing check.
//  tol negative: every element exceeds -> converged=0.
//  rst_cvg mid-check: immediate return to IDLE, all outputs to reset values, no done.
// CONFIGURATION
//  CVG_MAXDEV_EN defined: extra output max_dev [DW-1:0].
//   Tracks max abs_val seen during SCAN; negative values count as max positive.
//   Cleared to 0 on accepted start. Valid from done, held until next accepted start.
//   Reset value 0.
//  CVG_MAXDEV_EN undefined: port and register absent; all other behaviour identical.
// TESTING
//  T1 reset: rst_cvg=1 for 2 cycles with start=1 -> all outputs 0, en_abs never pulses.
//  T2 converge: tol=82, all 16 abs_val=40 -> en_abs cycle 1 only, done cycle 18,
//     converged=1, timeout=0, iter_cnt=1.
//  T3 single outlier: tol=82, element 15 = 83, others 0 -> converged=0.
//     Repeat with element 15 = 82 -> converged=1 (boundary inclusive).
//  T4 timeout: MAX_ITER=3, abs_val=8192 always, 4 checks -> timeout=0,0,1,1;
//     iter_cnt=1,2,3,3.
//  T5 interference: start pulsed in cycles 5 and 18 -> only one check, single done.
//     iter_clr in DECIDE cycle -> iter_cnt=0.
//  T6 abort: rst_cvg in cycle 10 of a check -> IDLE next cycle, no done.
//     New start completes normally. With CVG_MAXDEV_EN: max_dev = largest injected value.

Source files
------------

// File: rtl/symm_conv_ctrl.sv
// symm_conv_ctrl: convergence-check sequencer for the FastICA symmetric
// decorrelation step. Pulses the SYMM_ABS enable, scans its NELEM deviation
// outputs through an external mux, compares each against a tolerance and
// reports converged / timeout together with a saturating iteration count.
// Optional feature: define CVG_MAXDEV_EN to add the max_dev output.
module symm_conv_ctrl #(
  parameter int unsigned DW       = 26,
  parameter int unsigned NELEM    = 16,
  parameter int unsigned MAX_ITER = 200,
  parameter int unsigned ITER_W   = 8
) (
  input  logic              clk_cvg,
  input  logic              rst_cvg,
  input  logic              start,
  input  logic              iter_clr,
  input  logic [DW-1:0]     tol,
  output logic              en_abs,
  output logic [3:0]        abs_sel,
  input  logic [DW-1:0]     abs_val,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt
`ifdef CVG_MAXDEV_EN
  ,
  output logic [DW-1:0]     max_dev
`endif
);

  localparam int unsigned SEL_W = 4;
  localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(NELEM - 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LATCH  = 2'd1,
    S_SCAN   = 2'd2,
    S_DECIDE = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [DW-1:0]     tol_q, tol_n;
  logic              exceed, exceed_n;
  logic              en_abs_n, busy_n, done_n, conv_n, tmo_n;
  logic [SEL_W-1:0]  sel_n;
  logic [ITER_W-1:0] cnt_n, cnt_inc_c;
  logic              elem_fail_c;

  // Element fails when negative or above the registered tolerance
  assign elem_fail_c = abs_val[DW-1] | ($signed(abs_val) > $signed(tol_q));
  assign cnt_inc_c   = (iter_cnt >= ITER_MAX) ? ITER_MAX : (iter_cnt + ITER_W'(1));

`ifdef CVG_MAXDEV_EN
  logic [DW-1:0] maxdev_n, elem_mag_c;
  // Negative deviations are treated as the largest positive magnitude
  assign elem_mag_c = abs_val[DW-1] ? {1'b0, {(DW-1){1'b1}}} : abs_val;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    tol_n    = tol_q;
    exceed_n = exceed;
    en_abs_n = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    sel_n    = abs_sel;
    conv_n   = converged;
    tmo_n    = timeout;
    cnt_n    = iter_cnt;
`ifdef CVG_MAXDEV_EN
    maxdev_n = max_dev;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_LATCH;
          tol_n    = tol;
          exceed_n = 1'b0;
          conv_n   = 1'b0;
          tmo_n    = 1'b0;
          en_abs_n = 1'b1;
          busy_n   = 1'b1;
`ifdef CVG_MAXDEV_EN
          maxdev_n = '0;
`endif
        end
      end
      S_LATCH: begin
        state_n = S_SCAN;
        sel_n   = '0;
        busy_n  = 1'b1;
      end
      S_SCAN: begin
        exceed_n = exceed | elem_fail_c;
`ifdef CVG_MAXDEV_EN
        if (elem_mag_c > max_dev) maxdev_n = elem_mag_c;
`endif
        if (abs_sel == LAST_SEL) begin
          state_n = S_DECIDE;
          done_n  = 1'b1;
          conv_n  = ~exceed_n;
          cnt_n   = cnt_inc_c;
          tmo_n   = exceed_n & (cnt_inc_c == ITER_MAX);
        end else begin
          sel_n  = abs_sel + SEL_W'(1);
          busy_n = 1'b1;
        end
      end
      S_DECIDE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (iter_clr) cnt_n = '0;
  end

  // State and registered outputs
  always_ff @(posedge clk_cvg) begin
    if (rst_cvg) begin
      state     <= S_IDLE;
      tol_q     <= '0;
      exceed    <= 1'b0;
      en_abs    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      abs_sel   <= '0;
      converged <= 1'b0;
      timeout   <= 1'b0;
      iter_cnt  <= '0;
`ifdef CVG_MAXDEV_EN
      max_dev   <= '0;
`endif
    end else begin
      state     <= state_n;
      tol_q     <= tol_n;
      exceed    <= exceed_n;
      en_abs    <= en_abs_n;
      busy      <= busy_n;
      done      <= done_n;
      abs_sel   <= sel_n;
      converged <= conv_n;
      timeout   <= tmo_n;
      iter_cnt  <= cnt_n;
`ifdef CVG_MAXDEV_EN
      max_dev   <= maxdev_n;
`endif
    end
  end

endmodule

// File: tb/tb_symm_conv_ctrl.sv
// Scoreboard bench for symm_conv_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_symm_conv_ctrl;

  localparam int DW       = 26;
  localparam int NELEM    = 16;
  localparam int MAX_ITER = 3;
  localparam int ITER_W   = 8;
  localparam int MAXPOS   = (1 << (DW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic iter_clr = 1'b0;
  logic signed [DW-1:0] tol_s = '0;
  logic signed [DW-1:0] cur_vec [NELEM];
  logic [DW-1:0] abs_val;
  logic en_abs, busy, done, converged, timeout;
  logic [3:0] abs_sel;
  logic [ITER_W-1:0] iter_cnt;
`ifdef CVG_MAXDEV_EN
  logic [DW-1:0] max_dev;
`endif

  always #5 clk = ~clk;

  // External 16:1 mux model
  assign abs_val = cur_vec[abs_sel];

  symm_conv_ctrl #(.DW(DW), .NELEM(NELEM), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
    .clk_cvg(clk), .rst_cvg(rst), .start(start), .iter_clr(iter_clr), .tol(tol_s),
    .en_abs(en_abs), .abs_sel(abs_sel), .abs_val(abs_val), .busy(busy), .done(done),
    .converged(converged), .timeout(timeout), .iter_cnt(iter_cnt)
`ifdef CVG_MAXDEV_EN
    , .max_dev(max_dev)
`endif
  );

  typedef struct {
    bit  conv;
    bit  tmo;
    int  cnt;
    int  sc;
    int  md;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int st_cyc = -100;
  int done_cnt = 0;
  int en_cnt = 0;
  int model_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  // Monitor: en_abs timing and scoreboard pop on done
  always @(negedge clk) begin
    if (!rst) begin
      if (en_abs) begin
        en_cnt++;
        chk("en_abs_cycle", cyc, st_cyc + 1);
      end
      if (done) begin
        exp_t e;
        done_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("converged", int'(converged), int'(e.conv));
          chk("timeout", int'(timeout), int'(e.tmo));
          chk("iter_cnt", int'(iter_cnt), e.cnt);
          chk("done_cycle", cyc, e.sc + 18);
          chk("busy_at_done", int'(busy), 0);
`ifdef CVG_MAXDEV_EN
          chk("max_dev", int'(max_dev), e.md);
`endif
        end
      end
    end
  end

  // Reference: any element negative or above tol fails; saturating counter
  function automatic exp_t model(input bit clr);
    exp_t e;
    bit ex = 0;
    int mx = 0;
    int t = int'(tol_s);
    for (int i = 0; i < NELEM; i++) begin
      int v = int'(cur_vec[i]);
      if (v < 0 || v > t) ex = 1;
      if (v < 0) mx = MAXPOS;
      else if (v > mx) mx = v;
    end
    if (clr) model_cnt = 0;
    model_cnt = (model_cnt + 1 > MAX_ITER) ? MAX_ITER : model_cnt + 1;
    e.conv = !ex;
    e.tmo  = ex && (model_cnt == MAX_ITER);
    e.cnt  = model_cnt;
    e.sc   = cyc;
    e.md   = mx;
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a start (cur_vec and tol_s already set); called #1 after a posedge
  task automatic issue(input bit clr);
    st_cyc = cyc;
    q.push_back(model(clr));
    start = 1'b1;
    iter_clr = clr;
    step(1);
    start = 1'b0;
    iter_clr = 1'b0;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (done_cnt != d0) seen = 1;
    end
    if (!seen) begin
      chk("done_wait_timeout", 0, 1);
      q.delete();
    end
  endtask

  task automatic run_check(input bit clr);
    issue(clr);
    wait_done();
  endtask

  task automatic fill(input int val);
    for (int i = 0; i < NELEM; i++) cur_vec[i] = DW'(val);
  endtask

  initial begin
    int d0, e0, mode, idx, tv;
    fill(0);
    // T1: reset held with start asserted
    start = 1'b1;
    step(2);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_en_abs", int'(en_abs), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_converged", int'(converged), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_iter_cnt", int'(iter_cnt), 0);
    chk("rst_abs_sel", int'(abs_sel), 0);
    chk("rst_en_pulses", en_cnt, 0);

    // T2: converge
    tol_s = 26'sd82;
    fill(40);
    run_check(1'b1);
    chk("t2_en_pulses", en_cnt, 1);

    // T3: single outlier above and at the boundary
    fill(0);
    cur_vec[15] = 26'sd83;
    run_check(1'b0);
    cur_vec[15] = 26'sd82;
    run_check(1'b0);

    // T4: timeout sequence from a fresh count
    fill(8192);
    for (int k = 0; k < 4; k++) run_check(k == 0);

    // T5: starts during busy and on done are ignored; iter_clr on done clears
    fill(10);
    d0 = done_cnt;
    issue(1'b1);
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(12);
    start = 1'b1;
    iter_clr = 1'b1;
    step(1);
    start = 1'b0;
    iter_clr = 1'b0;
    model_cnt = 0;
    chk("t5_iter_clr", int'(iter_cnt), 0);
    e0 = en_cnt;
    step(25);
    chk("t5_single_done", done_cnt, d0 + 1);
    chk("t5_no_restart", en_cnt, e0);

    // T6: reset mid-check aborts with no done
    d0 = done_cnt;
    issue(1'b0);
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    q.delete();
    model_cnt = 0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_en_abs", int'(en_abs), 0);
    chk("t6_converged", int'(converged), 0);
    chk("t6_iter_cnt", int'(iter_cnt), 0);
    step(25);
    chk("t6_no_done", done_cnt, d0);
    for (int i = 0; i < NELEM; i++) cur_vec[i] = DW'($urandom_range(0, 60));
    cur_vec[7] = 26'sd5000;
    tol_s = 26'sd6000;
    run_check(1'b0);

    // Randomized checks
    for (int n = 0; n < 40; n++) begin
      tv = ($urandom_range(0, 9) == 0) ? -int'($urandom_range(1, 50)) : int'($urandom_range(0, 300));
      tol_s = DW'(tv);
      mode = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, NELEM - 1));
      for (int i = 0; i < NELEM; i++)
        cur_vec[i] = DW'($urandom_range(0, (tv > 0) ? tv : 0));
      case (mode)
        1: cur_vec[idx] = DW'(tv + 1);
        2: cur_vec[idx] = DW'(-int'($urandom_range(1, 1000)));
        3: cur_vec[idx] = DW'($urandom_range(0, 100000));
        default: ;
      endcase
      run_check($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) step(int'($urandom_range(1, 3)));
    end

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
